// File: rtl/m68k_bus_sequencer.sv
// ---------------------------------------------------------------------------
// m68k_bus_sequencer
// Queued 68000 bus-cycle engine. Pi-side requests are buffered in a small
// FIFO and executed back-to-back as 16-bit Amiga bus cycles; long transfers
// run as two word cycles (high word first). Each request yields exactly one
// status-tagged response (ok / BERR / timeout / address error).
//
// Ports
//   SYSCLK, RESET            system clock, async active-high reset
//   MC_RISING, MC_FALLING    one-SYSCLK pulses at the CLK_7M edges
//   DTACK_LATCH              one-SYSCLK pulse: sample DTACK_N / BERR_N
//   DTACK_N, BERR_N, D_IN    synchronised bus inputs
//   REQ_*                    request push interface (valid/ready)
//   RSP_*                    response interface (valid/ready)
//   A_OUT, FC_OUT, D_OUT     bus address (bits [AW-1:1]), function code, data
//   A_OE, D_OE, CTRL_OE      drive enables
//   AS, UDS, LDS, RW         bus strobes (active-high) and direction
//   BUSY                     sequencer not idle
// ---------------------------------------------------------------------------
module m68k_bus_sequencer #(
    parameter int ADDR_WIDTH     = 24,
    parameter int REQ_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  SYSCLK,
    input  logic                  RESET,
    input  logic                  MC_RISING,
    input  logic                  MC_FALLING,
    input  logic                  DTACK_LATCH,
    input  logic                  DTACK_N,
    input  logic                  BERR_N,
    input  logic [15:0]           D_IN,
    input  logic                  REQ_VALID,
    output logic                  REQ_READY,
    input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
    input  logic [1:0]            REQ_SIZE,
    input  logic                  REQ_READ,
    input  logic [2:0]            REQ_FC,
    input  logic [31:0]           REQ_WDATA,
    output logic                  RSP_VALID,
    input  logic                  RSP_READY,
    output logic [31:0]           RSP_RDATA,
    output logic [1:0]            RSP_STATUS,
    output logic [ADDR_WIDTH-2:0] A_OUT,
    output logic [2:0]            FC_OUT,
    output logic [15:0]           D_OUT,
    output logic                  A_OE,
    output logic                  D_OE,
    output logic                  CTRL_OE,
    output logic                  AS,
    output logic                  UDS,
    output logic                  LDS,
    output logic                  RW,
    output logic                  BUSY
);

    localparam int PW = $clog2(REQ_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [PW:0]   PTR_ONE  = 1;
    localparam logic [TW-1:0] TCNT_ONE = 1;
    localparam logic [TW-1:0] TCNT_MAX = TW'(TIMEOUT_CYCLES);

    localparam logic [3:0] ST_IDLE  = 4'd0;
    localparam logic [3:0] ST_SETUP = 4'd1;
    localparam logic [3:0] ST_S2    = 4'd2;
    localparam logic [3:0] ST_S3    = 4'd3;
    localparam logic [3:0] ST_S4    = 4'd4;
    localparam logic [3:0] ST_WAIT  = 4'd5;
    localparam logic [3:0] ST_S6    = 4'd6;
    localparam logic [3:0] ST_S7    = 4'd7;
    localparam logic [3:0] ST_END   = 4'd8;
    localparam logic [3:0] ST_RESP  = 4'd9;

    // Word presented on D_OUT; a byte write is replicated on both lanes.
    function automatic logic [15:0] bus_word(input logic [1:0] size, input logic first,
                                             input logic [31:0] wdata);
        if (size[1])
            return first ? wdata[31:16] : wdata[15:0];
        else if (size == 2'b00)
            return {wdata[7:0], wdata[7:0]};
        else
            return wdata[15:0];
    endfunction

    function automatic logic [7:0] byte_lane(input logic [15:0] d, input logic a0);
        return a0 ? d[7:0] : d[15:8];
    endfunction

    logic [ADDR_WIDTH-1:0] fifo_addr  [REQ_DEPTH];
    logic [1:0]            fifo_size  [REQ_DEPTH];
    logic                  fifo_read  [REQ_DEPTH];
    logic [2:0]            fifo_fc    [REQ_DEPTH];
    logic [31:0]           fifo_wdata [REQ_DEPTH];
    logic [PW:0]           wr_ptr, rd_ptr;

    logic [3:0]            state;
    logic [TW-1:0]         tcnt;
    logic                  term;

    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [1:0]            cur_size;
    logic                  cur_read;
    logic [2:0]            cur_fc;
    logic [31:0]           cur_wdata;
    logic                  first;
    logic [1:0]            cur_status;
    logic [31:0]           rdata_q;

    logic full, empty, push, pop, addr_err;
    logic wait_hit, wait_to, cont, enter_setup;

    assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign push  = REQ_VALID && !full;
    // RSP_VALID is only ever high in RESP, so popping from IDLE implies it is low.
    assign pop   = (state == ST_IDLE) && !empty;
    assign addr_err = (fifo_size[rd_ptr[PW-1:0]] != 2'b00) && fifo_addr[rd_ptr[PW-1:0]][0];

    // BERR has priority over DTACK; a bus acknowledge beats a same-cycle timeout.
    assign wait_hit = (state == ST_WAIT) && !term && DTACK_LATCH && (!BERR_N || !DTACK_N);
    assign wait_to  = (state == ST_WAIT) && !term && !wait_hit && (tcnt == TCNT_MAX);
    assign cont     = (state == ST_END) && cur_size[1] && first && (cur_status == 2'b00);
    assign enter_setup = (pop && !addr_err) || cont;

    always_ff @(posedge SYSCLK or posedge RESET) begin
        if (RESET) begin
            state  <= ST_IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            tcnt   <= '0;
            term   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case (state)
                // Address errors pass through END so no bus cycle is started.
                ST_IDLE:  if (pop) state <= addr_err ? ST_END : ST_SETUP;
                ST_SETUP: if (MC_RISING) state <= ST_S2;
                ST_S2:    if (MC_FALLING) state <= ST_S3;
                ST_S3:    if (MC_RISING) state <= ST_S4;
                ST_S4:    state <= ST_WAIT;
                ST_WAIT:  if (term && MC_FALLING) state <= ST_S6;
                ST_S6:    if (MC_FALLING) state <= ST_S7;
                ST_S7:    if (MC_RISING) state <= ST_END;
                ST_END:   state <= cont ? ST_SETUP : ST_RESP;
                ST_RESP:  if (RSP_READY) state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
            if (enter_setup) begin
                tcnt <= '0;
                term <= 1'b0;
            end else if ((state == ST_WAIT) && !term) begin
                if (wait_hit || wait_to) term <= 1'b1;
                if (MC_FALLING && (tcnt != TCNT_MAX)) tcnt <= tcnt + TCNT_ONE;
            end
        end
    end

    always_ff @(posedge SYSCLK) begin
        if (push) begin
            fifo_addr[wr_ptr[PW-1:0]]  <= REQ_ADDR;
            fifo_size[wr_ptr[PW-1:0]]  <= REQ_SIZE;
            fifo_read[wr_ptr[PW-1:0]]  <= REQ_READ;
            fifo_fc[wr_ptr[PW-1:0]]    <= REQ_FC;
            fifo_wdata[wr_ptr[PW-1:0]] <= REQ_WDATA;
        end
        if (pop) begin
            cur_addr   <= fifo_addr[rd_ptr[PW-1:0]];
            cur_size   <= fifo_size[rd_ptr[PW-1:0]];
            cur_read   <= fifo_read[rd_ptr[PW-1:0]];
            cur_fc     <= fifo_fc[rd_ptr[PW-1:0]];
            cur_wdata  <= fifo_wdata[rd_ptr[PW-1:0]];
            first      <= 1'b1;
            rdata_q    <= '0;
            cur_status <= addr_err ? 2'b11 : 2'b00;
        end
        if (wait_hit)
            cur_status <= BERR_N ? 2'b00 : 2'b01;
        else if (wait_to)
            cur_status <= 2'b10;
        if ((state == ST_S6) && MC_FALLING && cur_read) begin
            if (cur_size == 2'b00)
                rdata_q[7:0] <= byte_lane(D_IN, cur_addr[0]);
            else if (cur_size[1] && first)
                rdata_q[31:16] <= D_IN;
            else
                rdata_q[15:0] <= D_IN;
        end
        if (cont) begin
            cur_addr <= cur_addr + ADDR_WIDTH'(2);
            first    <= 1'b0;
        end
    end

    logic on_bus, ds_on;

    always_comb begin
        on_bus  = state inside {ST_SETUP, ST_S2, ST_S3, ST_S4, ST_WAIT, ST_S6, ST_S7};
        A_OE    = on_bus || cont;
        CTRL_OE = on_bus || cont;
        AS      = state inside {ST_S2, ST_S3, ST_S4, ST_WAIT, ST_S6};
        // Reads strobe data from S2, writes only once data is stable (S4).
        ds_on   = cur_read ? AS : (state inside {ST_S4, ST_WAIT, ST_S6});
        UDS     = ds_on && ((cur_size != 2'b00) || !cur_addr[0]);
        LDS     = ds_on && ((cur_size != 2'b00) || cur_addr[0]);
        RW      = (state inside {ST_S2, ST_S3, ST_S4, ST_WAIT, ST_S6, ST_S7}) ? cur_read : 1'b1;
        D_OE    = !cur_read && (state inside {ST_S3, ST_S4, ST_WAIT, ST_S6, ST_S7});
        D_OUT   = D_OE ? bus_word(cur_size, first, cur_wdata) : 16'h0000;
        A_OUT   = A_OE ? cur_addr[ADDR_WIDTH-1:1] : '0;
        FC_OUT  = A_OE ? cur_fc : 3'b000;
        RSP_VALID  = (state == ST_RESP);
        RSP_RDATA  = RSP_VALID ? rdata_q : 32'h0;
        RSP_STATUS = RSP_VALID ? cur_status : 2'b00;
        REQ_READY  = !full;
        BUSY       = (state != ST_IDLE);
    end

endmodule

// File: tb/tb_m68k_bus_sequencer.sv
module tb_m68k_bus_sequencer;

    localparam int AW = 24;

    logic          SYSCLK = 1'b0;
    logic          RESET;
    logic          MC_RISING, MC_FALLING, DTACK_LATCH;
    logic          DTACK_N, BERR_N;
    logic [15:0]   D_IN;
    logic          REQ_VALID, REQ_READY;
    logic [AW-1:0] REQ_ADDR;
    logic [1:0]    REQ_SIZE;
    logic          REQ_READ;
    logic [2:0]    REQ_FC;
    logic [31:0]   REQ_WDATA;
    logic          RSP_VALID, RSP_READY;
    logic [31:0]   RSP_RDATA;
    logic [1:0]    RSP_STATUS;
    logic [AW-2:0] A_OUT;
    logic [2:0]    FC_OUT;
    logic [15:0]   D_OUT;
    logic          A_OE, D_OE, CTRL_OE, AS, UDS, LDS, RW, BUSY;

    m68k_bus_sequencer #(.ADDR_WIDTH(AW), .REQ_DEPTH(4), .TIMEOUT_CYCLES(8)) dut (
        .SYSCLK(SYSCLK), .RESET(RESET), .MC_RISING(MC_RISING), .MC_FALLING(MC_FALLING),
        .DTACK_LATCH(DTACK_LATCH), .DTACK_N(DTACK_N), .BERR_N(BERR_N), .D_IN(D_IN),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_ADDR(REQ_ADDR),
        .REQ_SIZE(REQ_SIZE), .REQ_READ(REQ_READ), .REQ_FC(REQ_FC), .REQ_WDATA(REQ_WDATA),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RDATA(RSP_RDATA),
        .RSP_STATUS(RSP_STATUS), .A_OUT(A_OUT), .FC_OUT(FC_OUT), .D_OUT(D_OUT),
        .A_OE(A_OE), .D_OE(D_OE), .CTRL_OE(CTRL_OE), .AS(AS), .UDS(UDS), .LDS(LDS),
        .RW(RW), .BUSY(BUSY)
    );

    always #5 SYSCLK = ~SYSCLK;

    int checks = 0;
    int passed = 0;
    int ph = 0;

    // CLK_7M emulation: one MC period = 8 SYSCLK
    initial begin
        MC_RISING = 1'b0; MC_FALLING = 1'b0; DTACK_LATCH = 1'b0;
        forever begin
            @(negedge SYSCLK);
            ph = (ph + 1) % 8;
            MC_RISING   = (ph == 0);
            MC_FALLING  = (ph == 4);
            DTACK_LATCH = (ph == 6);
        end
    end

    // observations from the last transaction
    int            n_as, as_cyc, rsp_iter;
    logic [AW-2:0] alog [4];
    logic [15:0]   dlog [4];
    logic [2:0]    fc_seen;
    logic          saw_uds, saw_lds, rw_low, doe_s2, doe_s7, doe_ds_bad, hit_watch;
    logic          got_rsp, drives_at_rsp;
    logic [1:0]    r_status;
    logic [31:0]   r_rdata;
    logic [AW-2:0] watch_a;

    task automatic push_req(input logic [AW-1:0] addr, input logic [1:0] size,
                            input logic rd, input logic [2:0] fc, input logic [31:0] wd);
        REQ_ADDR = addr; REQ_SIZE = size; REQ_READ = rd; REQ_FC = fc; REQ_WDATA = wd;
        REQ_VALID = 1'b1;
        @(posedge SYSCLK); #1;
        REQ_VALID = 1'b0;
    endtask

    // mode 0: DTACK responder, 1: BERR responder, 2: no response
    task automatic run_txn(input int mode, input logic [15:0] din);
        logic prev_as, prev_ds;
        prev_as = 1'b0; prev_ds = 1'b0;
        n_as = 0; as_cyc = 0; rsp_iter = -1; fc_seen = 3'b000;
        saw_uds = 0; saw_lds = 0; rw_low = 0; doe_s2 = 0; doe_s7 = 0; doe_ds_bad = 0;
        hit_watch = 0; got_rsp = 0; drives_at_rsp = 0;
        for (int k = 0; k < 4; k++) begin alog[k] = '0; dlog[k] = '0; end
        D_IN = din;
        for (int i = 0; i < 600 && !got_rsp; i++) begin
            if (RSP_VALID) begin
                got_rsp = 1; rsp_iter = i;
                r_status = RSP_STATUS; r_rdata = RSP_RDATA;
                drives_at_rsp = A_OE | D_OE | CTRL_OE | AS | UDS | LDS;
            end else begin
                if (AS && !prev_as) begin
                    if (n_as < 4) alog[n_as] = A_OUT;
                    fc_seen = FC_OUT;
                    if (D_OE) doe_s2 = 1;
                    n_as++;
                end
                if (!AS && prev_as && D_OE) doe_s7 = 1;
                if (AS) as_cyc++;
                if (UDS) saw_uds = 1;
                if (LDS) saw_lds = 1;
                if ((UDS | LDS) && !RW && !D_OE) doe_ds_bad = 1;
                if ((UDS | LDS) && D_OE && !prev_ds && n_as > 0 && n_as <= 4) dlog[n_as-1] = D_OUT;
                if (RW !== 1'b1) rw_low = 1;
                if (A_OE && A_OUT == watch_a) hit_watch = 1;
                prev_as = AS; prev_ds = UDS | LDS;
                DTACK_N = !(AS && mode == 0);
                BERR_N  = !(AS && mode == 1);
                @(posedge SYSCLK); #1;
            end
        end
        DTACK_N = 1'b1; BERR_N = 1'b1;
        checks++;
        if (!got_rsp) $display("FAIL rsp_wait: no response within 600 cycles (required RSP_VALID=1)");
        else passed++;
    endtask

    task automatic ack_rsp();
        RSP_READY = 1'b1;
        @(posedge SYSCLK); #1;
        RSP_READY = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        repeat (3) @(posedge SYSCLK);
        #1;
        checks++; if (REQ_READY !== 1'b1) $display("FAIL reset_ready: got %b want 1", REQ_READY); else passed++;
        checks++; if (RW !== 1'b1) $display("FAIL reset_rw: got %b want 1", RW); else passed++;
        checks++;
        if ({A_OE, D_OE, CTRL_OE, AS, UDS, LDS, BUSY, RSP_VALID} !== 8'h00)
            $display("FAIL reset_ctrl: got %b want 00000000", {A_OE, D_OE, CTRL_OE, AS, UDS, LDS, BUSY, RSP_VALID});
        else passed++;
        checks++;
        if ({A_OUT, FC_OUT, D_OUT, RSP_RDATA, RSP_STATUS} !== '0)
            $display("FAIL reset_data: got a=%h fc=%h d=%h rd=%h st=%b want 0", A_OUT, FC_OUT, D_OUT, RSP_RDATA, RSP_STATUS);
        else passed++;
        RESET = 1'b0;
        @(posedge SYSCLK); #1;
    endtask

    task automatic test_word_read();
        watch_a = '1;
        push_req(24'hBFE000, 2'b01, 1'b1, 3'b101, 32'h0);
        run_txn(0, 16'h1234);
        checks++; if (r_status !== 2'b00) $display("FAIL wr_status: got %b want 00", r_status); else passed++;
        checks++; if (r_rdata !== 32'h0000_1234) $display("FAIL wr_rdata: got %h want 00001234", r_rdata); else passed++;
        checks++; if ({saw_uds, saw_lds} !== 2'b11) $display("FAIL wr_lanes: got uds=%b lds=%b want 11", saw_uds, saw_lds); else passed++;
        checks++; if (rw_low !== 1'b0) $display("FAIL wr_rw: got RW low=%b want 0", rw_low); else passed++;
        checks++; if (n_as != 1 || alog[0] !== 23'h5FF000) $display("FAIL wr_addr: got n_as=%0d a=%h want 1 5ff000", n_as, alog[0]); else passed++;
        checks++; if (fc_seen !== 3'b101) $display("FAIL wr_fc: got %b want 101", fc_seen); else passed++;
        checks++; if (drives_at_rsp !== 1'b0) $display("FAIL wr_release: got %b want 0", drives_at_rsp); else passed++;
        ack_rsp();
        checks++; if (RSP_VALID !== 1'b0) $display("FAIL wr_ack: got %b want 0", RSP_VALID); else passed++;
    endtask

    task automatic test_long_write();
        watch_a = '1;
        push_req(24'h000100, 2'b10, 1'b0, 3'b001, 32'hDEADBEEF);
        run_txn(0, 16'h0000);
        checks++; if (r_status !== 2'b00) $display("FAIL lw_status: got %b want 00", r_status); else passed++;
        checks++; if (n_as != 2) $display("FAIL lw_cycles: got %0d want 2", n_as); else passed++;
        checks++; if (alog[0] !== 23'h000080 || alog[1] !== 23'h000081) $display("FAIL lw_addr: got %h,%h want 000080,000081", alog[0], alog[1]); else passed++;
        checks++; if (dlog[0] !== 16'hDEAD || dlog[1] !== 16'hBEEF) $display("FAIL lw_data: got %h,%h want dead,beef", dlog[0], dlog[1]); else passed++;
        checks++; if (doe_ds_bad !== 1'b0) $display("FAIL lw_doe: got ds-without-doe=%b want 0", doe_ds_bad); else passed++;
        ack_rsp();
        repeat (20) @(posedge SYSCLK);
        #1;
        checks++; if ({RSP_VALID, BUSY} !== 2'b00) $display("FAIL lw_single: got valid=%b busy=%b want 00", RSP_VALID, BUSY); else passed++;
    endtask

    task automatic test_byte_write();
        watch_a = '1;
        push_req(24'h000101, 2'b00, 1'b0, 3'b001, 32'h0000005A);
        run_txn(0, 16'h0000);
        checks++; if ({saw_uds, saw_lds} !== 2'b01) $display("FAIL bw_lanes: got uds=%b lds=%b want 01", saw_uds, saw_lds); else passed++;
        checks++; if (doe_s2 !== 1'b0 || doe_s7 !== 1'b1 || doe_ds_bad !== 1'b0)
            $display("FAIL bw_doe: got s2=%b s7=%b dsbad=%b want 0 1 0", doe_s2, doe_s7, doe_ds_bad); else passed++;
        checks++; if (r_status !== 2'b00) $display("FAIL bw_status: got %b want 00", r_status); else passed++;
        ack_rsp();
    endtask

    task automatic test_byte_read();
        watch_a = '1;
        push_req(24'h000201, 2'b00, 1'b1, 3'b001, 32'h0);
        run_txn(0, 16'hABCD);
        checks++; if (r_rdata !== 32'h0000_00CD) $display("FAIL br_rdata: got %h want 000000cd", r_rdata); else passed++;
        checks++; if ({saw_uds, saw_lds} !== 2'b01) $display("FAIL br_lanes: got uds=%b lds=%b want 01", saw_uds, saw_lds); else passed++;
        ack_rsp();
    endtask

    task automatic test_timeout();
        watch_a = '1;
        push_req(24'h000400, 2'b01, 1'b1, 3'b001, 32'h0);
        run_txn(2, 16'h0000);
        checks++; if (r_status !== 2'b10) $display("FAIL to_status: got %b want 10", r_status); else passed++;
        // S2 4 + S3 4 + S4 1 + WAIT 67 (8 MC periods plus termination) + S6 8
        checks++; if (as_cyc != 84) $display("FAIL to_length: got AS cycles=%0d want 84", as_cyc); else passed++;
        checks++; if (drives_at_rsp !== 1'b0) $display("FAIL to_release: got %b want 0", drives_at_rsp); else passed++;
        ack_rsp();
    endtask

    task automatic test_berr_long();
        watch_a = 23'h000201;
        push_req(24'h000400, 2'b10, 1'b1, 3'b001, 32'h0);
        run_txn(1, 16'h5555);
        checks++; if (r_status !== 2'b01) $display("FAIL be_status: got %b want 01", r_status); else passed++;
        checks++; if (n_as != 1 || hit_watch !== 1'b0) $display("FAIL be_skip: got n_as=%0d hit=%b want 1 0", n_as, hit_watch); else passed++;
        ack_rsp();
    endtask

    task automatic test_addr_error();
        watch_a = '1;
        push_req(24'h000003, 2'b01, 1'b1, 3'b001, 32'h0);
        run_txn(0, 16'h0000);
        checks++; if (r_status !== 2'b11) $display("FAIL ae_status: got %b want 11", r_status); else passed++;
        checks++; if (n_as != 0) $display("FAIL ae_noas: got %0d AS pulses want 0", n_as); else passed++;
        checks++; if (rsp_iter != 2) $display("FAIL ae_latency: got %0d want 2", rsp_iter); else passed++;
        ack_rsp();
    endtask

    task automatic test_fifo_full();
        int drained;
        logic all_ae, got;
        push_req(24'h000003, 2'b01, 1'b1, 3'b001, 32'h0);
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            if (RSP_VALID) got = 1; else begin @(posedge SYSCLK); #1; end
        end
        checks++; if (!got) $display("FAIL ff_held: got RSP_VALID=0 want 1"); else passed++;
        for (int i = 0; i < 3; i++) push_req(24'h000005 + 2 * i, 2'b01, 1'b1, 3'b001, 32'h0);
        checks++; if (REQ_READY !== 1'b1) $display("FAIL ff_notfull: got %b want 1", REQ_READY); else passed++;
        push_req(24'h00000B, 2'b01, 1'b1, 3'b001, 32'h0);
        checks++; if (REQ_READY !== 1'b0) $display("FAIL ff_full: got %b want 0", REQ_READY); else passed++;
        push_req(24'h00000D, 2'b01, 1'b1, 3'b001, 32'h0);
        drained = 0; all_ae = 1;
        for (int k = 0; k < 8; k++) begin
            ack_rsp();
            got = 0;
            for (int i = 0; i < 10 && !got; i++) begin
                if (RSP_VALID) begin
                    got = 1; drained++;
                    if (RSP_STATUS !== 2'b11) all_ae = 0;
                end else begin
                    @(posedge SYSCLK); #1;
                end
            end
        end
        checks++; if (drained != 4) $display("FAIL ff_drain: got %0d queued responses want 4", drained); else passed++;
        checks++; if (all_ae !== 1'b1) $display("FAIL ff_status: got non-11 status want all 11"); else passed++;
    endtask

    task automatic test_reset_mid_cycle();
        logic found;
        push_req(24'h000300, 2'b01, 1'b0, 3'b001, 32'h00001111);
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (UDS && LDS) found = 1; else begin @(posedge SYSCLK); #1; end
        end
        checks++; if (!found) $display("FAIL rst_s4: never reached write strobe state"); else passed++;
        RESET = 1'b1;
        #1;
        checks++;
        if ({A_OE, D_OE, CTRL_OE, AS, UDS, LDS, BUSY} !== 7'h00 || RW !== 1'b1 || REQ_READY !== 1'b1)
            $display("FAIL rst_release: got oe=%b%b%b str=%b%b%b busy=%b rw=%b rdy=%b want 0 0 0 0 0 0 0 1 1",
                     A_OE, D_OE, CTRL_OE, AS, UDS, LDS, BUSY, RW, REQ_READY);
        else passed++;
        checks++; if ({A_OUT, D_OUT} !== '0) $display("FAIL rst_bus: got a=%h d=%h want 0", A_OUT, D_OUT); else passed++;
        @(posedge SYSCLK); #1;
        RESET = 1'b0;
        repeat (3) @(posedge SYSCLK);
        #1;
        checks++; if (BUSY !== 1'b0) $display("FAIL rst_flush: got BUSY=%b want 0", BUSY); else passed++;
    endtask

    task automatic test_back_to_back();
        watch_a = '1;
        push_req(24'h000500, 2'b01, 1'b1, 3'b010, 32'h0);
        push_req(24'h000600, 2'b01, 1'b1, 3'b010, 32'h0);
        run_txn(0, 16'h4321);
        checks++; if (r_status !== 2'b00 || r_rdata !== 32'h0000_4321) $display("FAIL b2b_first: got %b %h want 00 00004321", r_status, r_rdata); else passed++;
        ack_rsp();
        run_txn(0, 16'h8765);
        checks++; if (r_rdata !== 32'h0000_8765 || alog[0] !== 23'h000300) $display("FAIL b2b_second: got %h a=%h want 00008765 000300", r_rdata, alog[0]); else passed++;
        ack_rsp();
    endtask

    initial begin
        RESET = 1'b1; REQ_VALID = 1'b0; REQ_ADDR = '0; REQ_SIZE = 2'b00; REQ_READ = 1'b0;
        REQ_FC = 3'b000; REQ_WDATA = '0; RSP_READY = 1'b0; DTACK_N = 1'b1; BERR_N = 1'b1;
        D_IN = 16'h0000; watch_a = '1;
        test_reset();
        test_word_read();
        test_long_write();
        test_byte_write();
        test_byte_read();
        test_timeout();
        test_berr_long();
        test_addr_error();
        test_fifo_full();
        test_reset_mid_cycle();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
